// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the integer pipeline: opcodes, funct3 codes,
// the decoded-instruction kind and the default datapath width.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int REG_AW       = 5;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      KIND_ALU    = 1'b0,
      KIND_BRANCH = 1'b1
   } kind_e;

   // B-type offset bits, LSB always zero; the caller sign-extends from bit 12.
   function automatic logic [12:0] branch_offset(input logic [31:0] instr);
      return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports that forward a
// same-cycle write, one synchronous write port, x0 hardwired to zero.
module regfile
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREG = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [XLEN-1:0]   rdata1,
   output logic [XLEN-1:0]   rdata2,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata
);

   logic [XLEN-1:0] mem [NREG];

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   // NOTE: the array is reset because the core relies on all registers reading 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && waddr != '0) begin
         mem[waddr] <= wdata;
      end
   end

   // NOTE: each output is given a value on every path so no latch is inferred.
   always_comb begin
      rdata1 = mem[raddr1];
      if (raddr1 == '0)                  rdata1 = '0;
      else if (we && waddr == raddr1)    rdata1 = wdata;
   end

   always_comb begin
      rdata2 = mem[raddr2];
      if (raddr2 == '0)                  rdata2 = '0;
      else if (we && waddr == raddr2)    rdata2 = wdata;
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: OP / OP-IMM / BRANCH decode, operand read, busy scoreboard
// with writeback bypass, and a single valid/ready output register.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREG = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_kind,
   output logic [2:0]        out_funct3,
   output logic              out_mod,
   output logic [XLEN-1:0]   out_a,
   output logic [XLEN-1:0]   out_b,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_pc,
   output logic [REG_AW-1:0] out_rd,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              illegal
);

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [REG_AW-1:0] rs1, rs2, rd;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];

   logic is_op, is_op_imm, is_branch, is_legal, is_shift, use_rs2, sets_busy;

   always_comb begin
      is_op     = (opcode == OP);
      is_op_imm = (opcode == OP_IMM);
      is_branch = (opcode == BRANCH);
      is_legal  = is_op || is_op_imm || is_branch;
      is_shift  = is_op_imm && (funct3 == F3_SLL || funct3 == F3_SR);
      use_rs2   = is_op || is_branch;
      sets_busy = (is_op || is_op_imm) && (rd != '0);
   end

   logic [XLEN-1:0] rdata1, rdata2;

   regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .we     (wb_valid),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   logic [NREG-1:0] busy_q, busy_d;
   logic            rs1_busy, rs2_busy, stall, accept;

   // A source written back this very cycle is served by the regfile bypass.
   assign rs1_busy = busy_q[rs1] && !(wb_valid && wb_rd == rs1);
   assign rs2_busy = busy_q[rs2] && !(wb_valid && wb_rd == rs2);

   assign stall = (is_legal && rs1_busy)
                || (use_rs2 && rs2_busy)
                || (sets_busy && busy_q[rd])
                || (out_valid && !out_ready)
                || flush;

   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   kind_e             dec_kind;
   logic              dec_mod;
   logic [XLEN-1:0]   dec_b, dec_imm;
   logic [REG_AW-1:0] dec_rd;
   logic [12:0]       boff;

   always_comb begin
      boff     = branch_offset(in_instr);
      dec_kind = KIND_ALU;
      dec_mod  = 1'b0;
      dec_b    = rdata2;
      dec_imm  = '0;
      dec_rd   = rd;
      if (is_branch) begin
         dec_kind = KIND_BRANCH;
         dec_imm  = {{(XLEN-13){boff[12]}}, boff};
         dec_rd   = '0;
      end else if (is_op) begin
         dec_mod = in_instr[30];
      end else if (is_shift) begin
         dec_b   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
         dec_mod = (funct3 == F3_SR) && in_instr[30];
      end else if (is_op_imm) begin
         dec_b = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end
   end

   // Later assignments win: a new set overrides a same-cycle clear of that register.
   always_comb begin
      busy_d = busy_q;
      if (wb_valid)           busy_d[wb_rd]  = 1'b0;
      if (flush && out_valid) busy_d[out_rd] = 1'b0;
      if (accept && sets_busy) busy_d[rd]    = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         illegal    <= 1'b0;
         out_kind   <= KIND_ALU;
         out_funct3 <= '0;
         out_mod    <= 1'b0;
         out_a      <= '0;
         out_b      <= '0;
         out_imm    <= '0;
         out_pc     <= '0;
         out_rd     <= '0;
      end else begin
         illegal <= accept && !is_legal;
         if (flush)                     out_valid <= 1'b0;
         else if (accept && is_legal)   out_valid <= 1'b1;
         else if (out_ready)            out_valid <= 1'b0;
         if (accept && is_legal) begin
            out_kind   <= dec_kind;
            out_funct3 <= funct3;
            out_mod    <= dec_mod;
            out_a      <= rdata1;
            out_b      <= dec_b;
            out_imm    <= dec_imm;
            out_pc     <= in_pc;
            out_rd     <= dec_rd;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps followed by random
// traffic, compared against an architectural model of the decode stage.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic        out_kind;
   logic [2:0]  out_funct3;
   logic        out_mod;
   logic [31:0] out_a, out_b, out_imm, out_pc;
   logic [4:0]  out_rd;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        illegal;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .NREG(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_kind   (out_kind),
      .out_funct3 (out_funct3),
      .out_mod    (out_mod),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_imm    (out_imm),
      .out_pc     (out_pc),
      .out_rd     (out_rd),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .flush      (flush),
      .illegal    (illegal)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Architectural model: register values, pending-writeback set, held slot.
   typedef struct {
      bit          kind;
      logic [2:0]  f3;
      bit          mod;
      logic [31:0] a, b, imm, pc;
      logic [4:0]  rd;
   } held_t;

   logic [31:0] m_reg [32];
   bit          m_busy [32];
   bit          m_ov, m_ill;
   held_t       m_out, e_dec;
   bit          e_ready, e_acc, e_legal, e_sets;
   bit          last_ready;

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_reg[r]  = '0;
         m_busy[r] = 1'b0;
      end
      m_ov  = 1'b0;
      m_ill = 1'b0;
      m_out = '{default: '0};
   endtask

   function automatic logic [31:0] src_val(input logic [4:0] r);
      if (r == 0) return 32'd0;
      if (wb_valid && wb_rd == r) return wb_data;
      return m_reg[r];
   endfunction

   function automatic bit src_busy(input logic [4:0] r);
      if (r == 0) return 1'b0;
      return m_busy[r] && !(wb_valid && wb_rd == r);
   endfunction

   task automatic model_eval();
      logic [6:0] op;
      logic [2:0] f3;
      logic [4:0] r1, r2, rdx;
      bit         u1, u2;
      int         v;
      op  = in_instr[6:0];
      rdx = in_instr[11:7];
      f3  = in_instr[14:12];
      r1  = in_instr[19:15];
      r2  = in_instr[24:20];
      e_dec   = '{default: '0};
      e_legal = 1'b1;
      e_sets  = 1'b0;
      u1      = 1'b1;
      u2      = 1'b0;
      e_dec.pc = in_pc;
      e_dec.f3 = f3;
      e_dec.a  = src_val(r1);
      case (op)
         7'h33: begin
            e_dec.b   = src_val(r2);
            e_dec.mod = in_instr[30];
            e_dec.rd  = rdx;
            u2        = 1'b1;
            e_sets    = (rdx != 0);
         end
         7'h13: begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
               e_dec.b = 32'(in_instr[24:20]);
            end else begin
               v = int'(in_instr[31:20]);
               if (v >= 2048) v -= 4096;
               e_dec.b = 32'(v);
            end
            e_dec.mod = (f3 == 3'd5) ? in_instr[30] : 1'b0;
            e_dec.rd  = rdx;
            e_sets    = (rdx != 0);
         end
         7'h63: begin
            v = int'(in_instr[31]) * 4096 + int'(in_instr[7]) * 2048
              + int'(in_instr[30:25]) * 32 + int'(in_instr[11:8]) * 2;
            if (v >= 4096) v -= 8192;
            e_dec.kind = 1'b1;
            e_dec.b    = src_val(r2);
            e_dec.imm  = 32'(v);
            u2         = 1'b1;
         end
         default: begin
            e_legal = 1'b0;
            u1      = 1'b0;
         end
      endcase
      e_ready = !((u1 && src_busy(r1)) || (u2 && src_busy(r2))
                  || (e_sets && m_busy[rdx]) || (m_ov && !out_ready) || flush);
      e_acc = in_valid && e_ready;
   endtask

   task automatic model_commit();
      if (wb_valid) begin
         if (wb_rd != 0) m_reg[wb_rd] = wb_data;
         m_busy[wb_rd] = 1'b0;
      end
      if (flush && m_ov) m_busy[m_out.rd] = 1'b0;
      if (e_acc && e_sets) m_busy[e_dec.rd] = 1'b1;
      m_ill = e_acc && !e_legal;
      if (flush) m_ov = 1'b0;
      else if (e_acc && e_legal) begin
         m_ov  = 1'b1;
         m_out = e_dec;
      end else if (out_ready) m_ov = 1'b0;
   endtask

   // Inputs are set just after a rising edge; in_ready is sampled on the
   // falling edge and registered outputs 1 time unit after the next rising edge.
   task automatic cycle();
      @(negedge clk);
      model_eval();
      last_ready = in_ready;
      chk("in_ready", in_ready, e_ready);
      @(posedge clk);
      model_commit();
      #1;
      chk("out_valid", out_valid, m_ov);
      chk("illegal", illegal, m_ill);
      if (m_ov) begin
         chk("out_kind", out_kind, m_out.kind);
         chk("out_funct3", out_funct3, m_out.f3);
         chk("out_mod", out_mod, m_out.mod);
         chk("out_a", out_a, m_out.a);
         chk("out_b", out_b, m_out.b);
         chk("out_imm", out_imm, m_out.imm);
         chk("out_pc", out_pc, m_out.pc);
         chk("out_rd", out_rd, m_out.rd);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_illegal"}, illegal, 0);
      chk({tag, "_kind"}, out_kind, 0);
      chk({tag, "_funct3"}, out_funct3, 0);
      chk({tag, "_mod"}, out_mod, 0);
      chk({tag, "_a"}, out_a, 0);
      chk({tag, "_b"}, out_b, 0);
      chk({tag, "_imm"}, out_imm, 0);
      chk({tag, "_pc"}, out_pc, 0);
      chk({tag, "_rd"}, out_rd, 0);
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdx);
      return {f7, r2, r1, f3, rdx, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rdx);
      return {imm, r1, f3, rdx, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_b(input int off, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
      logic [12:0] o;
      o = 13'(off);
      return {o[12], o[10:5], r2, r1, f3, o[4:1], o[11], 7'b1100011};
   endfunction

   task automatic set_idle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wb_valid  = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
      flush     = 1'b0;
   endtask

   task automatic rand_instr();
      logic [31:0] w;
      int          sel;
      logic [6:0]  bad_ops [4];
      bad_ops = '{7'h03, 7'h37, 7'h6F, 7'h7F};
      w   = $urandom();
      sel = int'($urandom_range(9));
      if (sel <= 3)
         in_instr = enc_r({1'b0, w[30], 5'd0}, 5'(w[2:0]), 5'(w[5:3]), w[14:12], 5'(w[8:6]));
      else if (sel <= 6)
         in_instr = enc_i(w[31:20], 5'(w[2:0]), w[14:12], 5'(w[8:6]));
      else if (sel <= 8)
         in_instr = enc_b(int'($urandom_range(1023)) * 2 - 1024, 5'(w[2:0]), 5'(w[5:3]), w[14:12]);
      else
         in_instr = {w[31:7], bad_ops[$urandom_range(3)]};
      in_pc = $urandom() & 32'hFFFF_FFFC;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cand[$];

      rst_n    = 1'b0;
      set_idle();
      in_instr = '0;
      in_pc    = '0;
      model_reset();
      #1;
      chk_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // addi x1,x0,5
      in_valid = 1'b1;
      in_instr = 32'h0050_0093;
      in_pc    = 32'h0000_0100;
      cycle();
      chk("addi_accept", last_ready, 1);
      chk("addi_a", out_a, 0);
      chk("addi_b", out_b, 5);
      chk("addi_funct3", out_funct3, 0);
      chk("addi_mod", out_mod, 0);
      chk("addi_rd", out_rd, 1);

      // sub x3,x1,x2 waits on x1, then goes through on the writeback cycle
      in_instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
      in_pc    = 32'h0000_0104;
      cycle();
      chk("sub_raw_stall", last_ready, 0);
      wb_valid = 1'b1;
      wb_rd    = 5'd1;
      wb_data  = 32'd7;
      cycle();
      chk("sub_bypass_accept", last_ready, 1);
      chk("sub_a", out_a, 7);
      chk("sub_mod", out_mod, 1);
      chk("sub_rd", out_rd, 3);
      wb_valid = 1'b0;

      // srai x4,x5,3 then slli x6,x5,2
      in_instr = enc_i(12'h403, 5'd5, 3'd5, 5'd4);
      cycle();
      chk("srai_b", out_b, 3);
      chk("srai_mod", out_mod, 1);
      chk("srai_funct3", out_funct3, 5);
      in_instr = enc_i(12'h402, 5'd5, 3'd1, 5'd6);
      cycle();
      chk("slli_b", out_b, 2);
      chk("slli_mod", out_mod, 0);

      // beq x1,x2,-8
      in_instr = enc_b(-8, 5'd2, 5'd1, 3'd0);
      cycle();
      chk("beq_kind", out_kind, 1);
      chk("beq_imm", out_imm, 32'hFFFF_FFF8);
      chk("beq_rd", out_rd, 0);
      chk("beq_a", out_a, 7);

      // addi x7,x0,1 held for three cycles behind a second offer
      in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd7);
      cycle();
      out_ready = 1'b0;
      in_instr  = enc_i(12'd2, 5'd0, 3'd0, 5'd8);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("hold_ready", last_ready, 0);
         chk("hold_b", out_b, 1);
         chk("hold_rd", out_rd, 7);
      end
      flush = 1'b1;
      cycle();
      chk("flush_ready", last_ready, 0);
      chk("flush_valid", out_valid, 0);
      flush     = 1'b0;
      out_ready = 1'b1;
      in_instr  = enc_i(12'd2, 5'd0, 3'd0, 5'd7);
      cycle();
      chk("flush_freed_rd", last_ready, 1);

      // unsupported opcode
      in_instr = 32'h0000_007F;
      cycle();
      chk("illegal_pulse", illegal, 1);
      chk("illegal_no_out", out_valid, 0);
      in_valid = 1'b0;
      cycle();
      chk("illegal_one_cycle", illegal, 0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(4) != 0);
         out_ready = ($urandom_range(3) != 0);
         flush     = ($urandom_range(11) == 0);
         rand_instr();
         wb_valid  = ($urandom_range(2) == 0);
         cand.delete();
         for (int r = 1; r < 8; r++) if (m_busy[r]) cand.push_back(r);
         if (cand.size() > 0) wb_rd = 5'(cand[$urandom_range(cand.size() - 1)]);
         else                 wb_rd = 5'($urandom_range(7));
         wb_data = $urandom();
         cycle();
      end

      // retire everything still pending
      set_idle();
      for (int r = 1; r < 32; r++) begin
         wb_valid = 1'b1;
         wb_rd    = 5'(r);
         wb_data  = $urandom();
         cycle();
      end
      wb_valid = 1'b0;

      // reset in the middle of a stall
      in_valid = 1'b1;
      in_instr = enc_i(12'd3, 5'd0, 3'd0, 5'd10);
      cycle();
      out_ready = 1'b0;
      in_instr  = enc_r(7'h00, 5'd10, 5'd10, 3'd0, 5'd11);
      cycle();
      chk("pre_reset_stall", last_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_all_zero("midreset");
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      cycle();
      chk("post_reset_accept", last_ready, 1);
      chk("post_reset_a", out_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
